// File: rtl/myproject_mac_pkg.sv
// myproject_mac_pkg: shared constants, types and helpers for the pipelined
// signed multiply-accumulate unit (myproject_mac_pipe).
//   - default widths / pipeline depth
//   - prod_width(): full-precision signed product width
//   - sext(): sign-extend an arbitrary-width value held in 64 bits
//   - sat_add(): saturating signed add, used when MYPROJECT_MAC_SAT_EN is defined
//   - side_t: sideband flags travelling with each sample
// Helpers work on 64-bit containers, so ACC_WIDTH is limited to 62 bits.
package myproject_mac_pkg;

  localparam int DEF_DIN0_WIDTH = 16;
  localparam int DEF_DIN1_WIDTH = 7;
  localparam int DEF_ACC_WIDTH  = 32;
  localparam int DEF_NUM_STAGE  = 2;

  typedef struct packed {
    logic vld;
    logic clr;
    logic last;
  } side_t;

  typedef struct packed {
    logic signed [63:0] sum;
    logic               ovf;
  } sat_res_t;

  function automatic int prod_width(input int w0, input int w1);
    return w0 + w1;
  endfunction

  // Treat the low w bits of x as a signed number and extend it to 64 bits.
  function automatic logic signed [63:0] sext(input logic [63:0] x, input int w);
    return $signed(x << (64 - w)) >>> (64 - w);
  endfunction

  // Operands are already within the w-bit signed range, so the 64-bit sum
  // cannot wrap and a plain range compare detects the clamp.
  function automatic sat_res_t sat_add(input logic signed [63:0] a,
                                       input logic signed [63:0] b,
                                       input int w);
    sat_res_t           r;
    logic signed [63:0] s, hi, lo;
    s  = a + b;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    r.sum = s;
    r.ovf = 1'b0;
    if (s > hi) begin
      r.sum = hi;
      r.ovf = 1'b1;
    end else if (s < lo) begin
      r.sum = lo;
      r.ovf = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/myproject_mac_mul_pipe.sv
// myproject_mac_mul_pipe: NUM_STAGE-deep signed multiplier. The product is
// formed into the first register and then shifted through the remaining
// stages together with the {vld, clr, last} sideband.
// Ports:
//   clk, rst   clock, synchronous active-high reset (clears sideband only)
//   ce         clock enable, 0 freezes every stage
//   a, b       signed operands (DIN0_WIDTH / DIN1_WIDTH)
//   side_in    sideband for the sample on a/b
//   prod       full-precision product after NUM_STAGE registers
//   side_out   sideband aligned with prod
module myproject_mac_mul_pipe
  import myproject_mac_pkg::*;
#(
  parameter int DIN0_WIDTH = DEF_DIN0_WIDTH,
  parameter int DIN1_WIDTH = DEF_DIN1_WIDTH,
  parameter int NUM_STAGE  = DEF_NUM_STAGE,
  parameter int PW         = prod_width(DIN0_WIDTH, DIN1_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic [DIN0_WIDTH-1:0] a,
  input  logic [DIN1_WIDTH-1:0] b,
  input  side_t                 side_in,
  output logic [PW-1:0]         prod,
  output side_t                 side_out
);

  logic [PW-1:0] prod_r [1:NUM_STAGE];
  side_t         side_r [1:NUM_STAGE];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i <= NUM_STAGE; i++) side_r[i] <= '0;
    end else if (ce) begin
      side_r[1] <= side_in;
      for (int i = 2; i <= NUM_STAGE; i++) side_r[i] <= side_r[i-1];
    end
  end

  // Datapath registers need no reset: downstream only looks at them when
  // the matching vld bit is set.
  always_ff @(posedge clk) begin
    if (ce) begin
      prod_r[1] <= PW'($signed(a)) * PW'($signed(b));
      for (int i = 2; i <= NUM_STAGE; i++) prod_r[i] <= prod_r[i-1];
    end
  end

  assign prod     = prod_r[NUM_STAGE];
  assign side_out = side_r[NUM_STAGE];

endmodule

// File: rtl/myproject_mac_pipe.sv
// myproject_mac_pipe: pipelined signed multiply-accumulate. din0*din1 goes
// through NUM_STAGE multiplier registers, then valid samples are summed into
// an ACC_WIDTH-bit accumulator framed by acc_clr / acc_last. A sample with
// last loads dout and pulses dout_vld for one enabled cycle.
// Optional build macro: MYPROJECT_MAC_SAT_EN -- saturating accumulate and a
// sticky sat_ovf flag per sum; otherwise wrap arithmetic and sat_ovf = 0.
// Ports:
//   ap_clk, ap_rst   clock, synchronous active-high reset (overrides ce)
//   ce               clock enable for all state
//   din0, din1       signed operands
//   din_vld          sample valid; qualifies acc_clr / acc_last
//   acc_clr          sample starts a new sum
//   acc_last         sample ends the current sum
//   dout             last completed sum (held)
//   dout_vld         one-cycle pulse when dout is updated
//   sat_ovf          sticky clamp flag for the current sum
module myproject_mac_pipe
  import myproject_mac_pkg::*;
#(
  parameter int ID         = 1,
  parameter int DIN0_WIDTH = DEF_DIN0_WIDTH,
  parameter int DIN1_WIDTH = DEF_DIN1_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int NUM_STAGE  = DEF_NUM_STAGE
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ce,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  input  logic                  din_vld,
  input  logic                  acc_clr,
  input  logic                  acc_last,
  output logic [ACC_WIDTH-1:0]  dout,
  output logic                  dout_vld,
  output logic                  sat_ovf
);

  localparam int PW = prod_width(DIN0_WIDTH, DIN1_WIDTH);

  // Elaboration-time guard on the configuration space the helpers support.
  if (ID < 0 || NUM_STAGE < 1 || NUM_STAGE > 4 ||
      ACC_WIDTH < PW || ACC_WIDTH > 62) begin : g_bad_cfg
    $error("myproject_mac_pipe: unsupported parameter set");
  end

  side_t                       side_in, side_s;
  logic [PW-1:0]               prod;
  logic signed [ACC_WIDTH-1:0] acc, acc_nxt, dout_r;
  logic signed [63:0]          prod64, base64, sum64;
  logic [63-ACC_WIDTH:0]       unused_sum_hi;

  assign side_in = {din_vld, acc_clr, acc_last};

  myproject_mac_mul_pipe #(
    .DIN0_WIDTH (DIN0_WIDTH),
    .DIN1_WIDTH (DIN1_WIDTH),
    .NUM_STAGE  (NUM_STAGE),
    .PW         (PW)
  ) u_mul (
    .clk      (ap_clk),
    .rst      (ap_rst),
    .ce       (ce),
    .a        (din0),
    .b        (din1),
    .side_in  (side_in),
    .prod     (prod),
    .side_out (side_s)
  );

`ifdef MYPROJECT_MAC_SAT_EN
  sat_res_t sres;
  logic     ovf_nxt;
  logic     sat_r;
`endif

  // A clr sample restarts from zero, so the clr and add paths share one adder.
  always_comb begin
    prod64 = sext(64'(prod), PW);
    base64 = side_s.clr ? 64'sd0 : 64'(acc);
`ifdef MYPROJECT_MAC_SAT_EN
    sres    = sat_add(base64, prod64, ACC_WIDTH);
    sum64   = sres.sum;
    ovf_nxt = sres.ovf;
`else
    sum64   = base64 + prod64;
`endif
    acc_nxt = sum64[ACC_WIDTH-1:0];
  end

  // Upper bits only matter for the saturation compare; truncation is the wrap.
  assign unused_sum_hi = sum64[63:ACC_WIDTH];

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      acc      <= '0;
      dout_r   <= '0;
      dout_vld <= 1'b0;
    end else if (ce) begin
      dout_vld <= 1'b0;
      if (side_s.vld) begin
        acc <= acc_nxt;
        if (side_s.last) begin
          dout_r   <= acc_nxt;
          dout_vld <= 1'b1;
        end
      end
    end
  end

  assign dout = dout_r;

`ifdef MYPROJECT_MAC_SAT_EN
  // Sticky across the sum; a clr sample restarts it from that sample's add.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      sat_r <= 1'b0;
    end else if (ce && side_s.vld) begin
      sat_r <= side_s.clr ? ovf_nxt : (sat_r | ovf_nxt);
    end
  end
  assign sat_ovf = sat_r;
`else
  assign sat_ovf = 1'b0;
`endif

endmodule

// File: doc/myproject_mac_pipe.md
Name: myproject_mac_pipe

Overview:
- Parametrised, pipelined signed multiply-accumulate unit; the successor to the fixed-width single-cycle signed multiplier cores.
- Computes din0*din1 over NUM_STAGE register stages, then accumulates products into ACC_WIDTH-bit sums framed by clr/last sideband flags.
- Sits inside the GNN aggregation datapath, where per-edge weighted messages are summed into per-node results.

Parameters:
ID, 1, instance identifier; no functional effect
DIN0_WIDTH, 16, signed width of din0
DIN1_WIDTH, 7, signed width of din1
ACC_WIDTH, 32, accumulator/output width; must be >= DIN0_WIDTH+DIN1_WIDTH
NUM_STAGE, 2, multiplier pipeline depth, legal range 1..4

Ports:
ap_clk  in  1  clock
ap_rst  in  1  synchronous active-high reset
ce  in  1  clock enable; 0 freezes every register
din0  in  DIN0_WIDTH  signed multiplicand
din1  in  DIN1_WIDTH  signed multiplier
din_vld  in  1  input sample valid
acc_clr  in  1  sample starts a new sum; qualified by din_vld
acc_last  in  1  sample ends the current sum; qualified by din_vld
dout  out  ACC_WIDTH  signed accumulated result
dout_vld  out  1  one-cycle pulse: dout holds a completed sum
sat_ovf  out  1  sticky saturation flag for the current sum

Behaviour:
- Reset (ap_rst=1 at a clock edge, independent of ce):
  - clears all pipeline valid bits, the accumulator, dout, dout_vld and sat_ovf;
  - in-flight samples are discarded, and no dout_vld pulse occurs for them.
- Product: full-precision signed product of DIN0_WIDTH+DIN1_WIDTH bits, sign-extended to ACC_WIDTH.
  - Carried through NUM_STAGE registers, with vld/clr/last travelling alongside.
- Accumulate stage, on a valid sample only:
  - clr=1: acc <= product;
  - clr=0: acc <= acc + product.
  - Invalid slots (vld=0) leave acc unchanged; their clr/last are ignored.
- Output:
  - When a valid sample with last=1 updates acc, the same edge loads dout with the new acc and sets dout_vld=1.
  - dout_vld falls on the next enabled edge; dout holds its value until the next completed sum.
- Latency: a sample presented at edge k with last=1 yields dout_vld=1 after edge k+NUM_STAGE+1 (with ce continuously 1).
- Throughput: one sample per cycle; no backpressure.
- ce=0: all state holds, including a dout_vld already at 1, which stays high until the next enabled edge.
- Boundary cases:
  - clr and last on the same sample: dout = that product alone.
  - First sample after reset without clr accumulates onto 0.
  - A packet ending with last and the next packet's clr on the following cycle gives dout_vld on consecutive cycles.
  - Overflow without the optional feature: two's-complement wrap modulo 2^ACC_WIDTH, and sat_ovf stays 0.

Optional Feature:
MYPROJECT_MAC_SAT_EN
- Defined:
  - The accumulate add saturates to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
  - sat_ovf is set when any add in the current sum clamps; it is cleared by a clr sample or by reset.
  - sat_ovf is valid alongside dout_vld.
  - Adds one extra compare but no extra latency.
- Undefined: wrap arithmetic; sat_ovf tied to 0.

Decomposition:
- Package myproject_mac_pkg holds:
  - the default width constants;
  - a product-width localparam function (DIN0_WIDTH+DIN1_WIDTH);
  - a sign-extend function;
  - a saturating-add function, used under the macro;
  - a sideband struct typedef {vld, clr, last}.
- One sub-module, myproject_mac_mul_pipe: a NUM_STAGE-deep signed multiplier that carries the sideband struct, has a ce input and resets the valid bits.
- The accumulator and output logic stay in the top module.

Test Plan:
1. Single sample: din0=-32768, din1=-64, clr=last=1 -> dout_vld at edge k+3 (NUM_STAGE=2), dout=2097152, pulse exactly 1 cycle.
2. Four-sample sum: (100,3) with clr, (-200,5), (7,-64), (1,1) with last -> dout=-1147.
3. Same stimulus with din_vld gaps between samples and ce=0 for 2 cycles mid-stream -> dout=-1147, dout_vld delayed by exactly 2 enabled-edge-equivalent cycles.
4. Overflow, ACC_WIDTH=24, four samples of (-32768,-64) -> without macro dout=-8388608 and sat_ovf=0; with MYPROJECT_MAC_SAT_EN dout=8388607 and sat_ovf=1.
5. Reset mid-operation: ap_rst for 1 cycle with 2 samples in flight -> no dout_vld. Next packet (5,5) with last and no clr -> dout=25.
6. Back-to-back packets: A = (2,3) with clr+last, B = (4,-5) with clr+last on the next cycle -> dout_vld high 2 consecutive cycles, dout 6 then -20.
